// File: rtl/regfile_write_bank.sv
// ============================================================================
// Module   : regfile_write_bank
// Purpose  : Write side of the 32x64 integer register file: 2-entry write-back
//            FIFO draining into the register array, with a per-register
//            pending mask. Optional macro REGFILE_BYPASS_EN forwards buffered
//            writes onto regs_out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_bank #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_W     = 64,
    parameter int ZERO_REG   = 31,
    parameter int FIFO_DEPTH = 2,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             drain_stall,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_out,
    output logic [NUM_REGS-1:0]              pending,
    output logic [1:0]                       count
);

    localparam logic [1:0] c_full = 2'(FIFO_DEPTH);

    logic [ADDR_W-1:0] r_addr [0:1];
    logic [DATA_W-1:0] r_data [0:1];
    logic              r_head;
    logic [1:0]        r_count;

    logic              w_accept;
    logic              w_commit;
    logic              w_tail;
    logic              w_young;
    logic [1:0]        w_slot_vld;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [DATA_W-1:0] w_arr [0:NUM_REGS-1];

    assign wr_ready    = (r_count != c_full) & ~reset;
    assign w_accept    = wr_valid & wr_ready;
    assign w_commit    = (r_count != 2'd0) & ~drain_stall;
    assign w_tail      = r_head ^ r_count[0];
    // Youngest entry sits behind the head only when both slots are full.
    assign w_young     = r_head ^ r_count[1];
    assign w_head_addr = r_addr[r_head];
    assign w_head_data = r_data[r_head];
    assign count       = r_count;

    assign w_slot_vld[0] = r_count[1] | (r_count[0] & (r_head == 1'b0));
    assign w_slot_vld[1] = r_count[1] | (r_count[0] & (r_head == 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_commit) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_commit};
        end
    end

    // Payload storage needs no reset; validity is carried by r_count/r_head.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr[w_tail] <= wr_addr;
            r_data[w_tail] <= wr_data;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            if (i == ZERO_REG) begin : g_zero
                assign w_arr[i]    = '0;
                assign pending[i]  = 1'b0;
                assign regs_out[i] = '0;
            end else begin : g_live
                logic              r_q;
                logic [DATA_W-1:0] r_val;
                logic              w_we;
                logic              w_hit_y;
                logic              w_hit_o;

                assign w_we    = w_commit && (w_head_addr == ADDR_W'(i));
                assign w_hit_y = w_slot_vld[w_young]  && (r_addr[w_young]  == ADDR_W'(i));
                assign w_hit_o = w_slot_vld[~w_young] && (r_addr[~w_young] == ADDR_W'(i));

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_val <= '0;
                    end else if (w_we) begin
                        r_val <= w_head_data;
                    end
                end

                assign r_q        = 1'b0;
                assign w_arr[i]   = r_val;
                assign pending[i] = w_hit_y | w_hit_o | r_q;

`ifdef REGFILE_BYPASS_EN
                assign regs_out[i] = w_hit_y ? r_data[w_young]  :
                                     w_hit_o ? r_data[~w_young] : w_arr[i];
`else
                assign regs_out[i] = w_arr[i];
`endif
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_bank.sv
// ============================================================================
// Module   : tb_regfile_write_bank
// Purpose  : Directed self-checking bench for regfile_write_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_bank;

    logic               clk;
    logic               reset;
    logic               wr_valid;
    logic               wr_ready;
    logic [4:0]         wr_addr;
    logic [63:0]        wr_data;
    logic               drain_stall;
    logic [31:0][63:0]  regs_out;
    logic [31:0]        pending;
    logic [1:0]         count;

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_bank dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .drain_stall (drain_stall),
        .regs_out    (regs_out),
        .pending     (pending),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected view of a buffered-but-uncommitted write on regs_out.
    function automatic logic [63:0] early(input logic [63:0] committed, input logic [63:0] buffered);
`ifdef REGFILE_BYPASS_EN
        return buffered;
`else
        return committed;
`endif
    endfunction

    logic [31:0][63:0] exp_regs;

    initial begin
        reset = 1'b1; wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
        drain_stall = 1'b0;
        #1;
        check("ready_in_reset0", wr_ready, 0);
        tick(); tick();
        check("ready_in_reset1", wr_ready, 0);
        reset = 1'b0; wr_valid = 1'b0;
        #1;
        check("rst_ready", wr_ready, 1);
        check("rst_count", count, 0);
        check("rst_pending", pending, 0);
        check("rst_regs_zero", {63'd0, |regs_out}, 0);

        // Single write
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        wr_valid = 1'b0;
        check("sw_pending", pending, 32'h20);
        check("sw_count1", count, 1);
        check("sw_early_r5", regs_out[5], early(64'h0, 64'hDEADBEEF_CAFEF00D));
        tick();
        check("sw_r5", regs_out[5], 64'hDEADBEEF_CAFEF00D);
        check("sw_pending0", pending, 0);
        check("sw_count0", count, 0);
        exp_regs = regs_out;
        exp_regs[5] = 64'h0;
        check("sw_others_zero", {63'd0, |exp_regs}, 0);

        // Full / backpressure
        drain_stall = 1'b1;
        wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 64'h11;
        tick();
        wr_addr = 5'd2; wr_data = 64'h22;
        tick();
        wr_addr = 5'd3; wr_data = 64'h33;
        check("full_count", count, 2);
        check("full_ready", wr_ready, 0);
        check("full_pending", pending, 32'h6);
        check("full_early_r2", regs_out[2], early(64'h0, 64'h22));
        tick();
        check("full_hold_count", count, 2);
        check("full_hold_pending", pending, 32'h6);
        drain_stall = 1'b0;
        tick();
        check("drain_r1", regs_out[1], 64'h11);
        check("drain_count", count, 1);
        check("drain_ready", wr_ready, 1);
        check("drain_pending", pending, 32'h4);
        tick();
        wr_valid = 1'b0;
        check("acc_commit_count", count, 1);
        check("acc_commit_r2", regs_out[2], 64'h22);
        check("acc_commit_pending", pending, 32'h8);
        tick();
        check("final_r1", regs_out[1], 64'h11);
        check("final_r2", regs_out[2], 64'h22);
        check("final_r3", regs_out[3], 64'h33);
        check("final_count", count, 0);

        // Same-register ordering
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 64'hAAAA;
        tick();
        wr_data = 64'hBBBB;
        tick();
        wr_valid = 1'b0;
        check("ord_pending7", {63'd0, pending[7]}, 1);
        check("ord_mid_r7", regs_out[7], early(64'hAAAA, 64'hBBBB));
        tick();
        check("ord_r7", regs_out[7], 64'hBBBB);
        check("ord_pending0", pending, 0);

        // Zero register
        wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        wr_valid = 1'b0;
        check("zr_count1", count, 1);
        check("zr_pending", pending, 0);
        check("zr_r31_buf", regs_out[31], 0);
        tick();
        check("zr_count0", count, 0);
        check("zr_r31", regs_out[31], 0);

        // Reset mid-operation
        drain_stall = 1'b1;
        wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
        tick();
        wr_valid = 1'b0;
        check("mr_count1", count, 1);
        check("mr_pending", pending, 32'h10);
        check("mr_pre_r4", regs_out[4], early(64'h0, 64'h44));
        reset = 1'b1;
        tick();
        reset = 1'b0; drain_stall = 1'b0;
        #1;
        check("mr_count0", count, 0);
        check("mr_pending0", pending, 0);
        check("mr_r4", regs_out[4], 0);
        check("mr_r7_cleared", regs_out[7], 0);
        tick(); tick();
        check("mr_r4_no_commit", regs_out[4], 0);
        check("mr_count_stay0", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
Write side of the 32x64-bit integer register file. Takes write-back requests over a valid/ready handshake and buffers them in a 2-entry FIFO. Drains one entry per cycle into a 32x64 register array and presents the whole array, packed [31:0][63:0], to the read-port 32:1 64-bit muxes. Also exports a per-register pending mask so the read side can detect writes that are buffered but not yet committed.

Parameters:
NUM_REGS, 32, number of architectural registers; address width is clog2(NUM_REGS) = 5.
DATA_W, 64, register width in bits.
ZERO_REG, 31, index of the hardwired-zero register (XZR).
FIFO_DEPTH, 2, write buffer entries; only 2 is supported.

Ports:
clk  input  1  clock, all state updates on posedge.
reset  input  1  synchronous, active-high reset.
wr_valid  input  1  write request present.
wr_ready  output  1  bank can accept a request this cycle.
wr_addr  input  5  destination register index.
wr_data  input  64  write data.
drain_stall  input  1  when high, FIFO head is not committed this cycle.
regs_out  output  [31:0][63:0]  register array contents, feeds the read muxes.
pending  output  32  bit i high iff a buffered entry targets register i.
count  output  2  current FIFO occupancy, 0..2.

Behaviour:
- Accept: accept = wr_valid & wr_ready, sampled at posedge. The entry is appended to the FIFO tail.
- Ready: wr_ready = (count != 2) & ~reset. It depends on registered count only; there is no same-cycle full-and-drain pass-through.
- Drain: commit = (count != 0) & ~drain_stall.
  - At posedge, the head entry is written into array[head.addr], then popped.
  - An entry accepted at edge N is committed no earlier than edge N+1.
  - Its value is visible on regs_out after edge N+1.
- Simultaneous accept and commit: allowed when count is 1, and count stays 1. When count is 0, no commit occurs that cycle and count becomes 1.
- Count update: count_next = count + accept - commit, with no overflow or underflow possible.
- Write ordering: FIFO order. Two writes to the same register commit in acceptance order; the later value wins.
- Zero register: writes with addr == ZERO_REG are accepted and occupy a FIFO slot. At commit they are discarded.
  - regs_out[31] is constant 0.
  - pending[31] is constant 0.
- Pending: pending[i] = OR over valid entries e of (e.addr == i). It is combinational from FIFO state and deasserts in the cycle after the commit edge.
- Reset: synchronous, takes priority over everything.
  - Array cleared to 0; FIFO emptied; count = 0; pending = 0; wr_ready = 0 while reset is high.
  - Reset mid-operation discards buffered writes without committing them.
- Outputs: regs_out, pending and count are glitch-free functions of registered state. There is no combinational path from wr_* to any output except wr_ready, which has none.
- The write-enable decode is 5-to-32 one-hot on the head address, gated by commit and by addr != ZERO_REG.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: regs_out[i] shows, for each i != 31, the data of the youngest valid FIFO entry targeting i if one exists, otherwise array[i]. Buffered writes are therefore forwarded to readers one cycle early. pending is still driven unchanged for debug.
- Undefined: regs_out[i] = array[i], with committed values only.

Test Plan:
- Reset then idle: assert reset 2 cycles with wr_valid=1 -> wr_ready=0 during reset; after release regs_out all 0, count=0, pending=0, wr_ready=1.
- Single write: wr_addr=5, wr_data=0xDEADBEEF_CAFEF00D, one cycle.
  - Pending[5]=1 and count=1 after edge 1.
  - regs_out[5]=0xDEADBEEF_CAFEF00D, pending=0 and count=0 after edge 2.
  - All other registers remain 0.
- Full/backpressure: drain_stall=1, write r1=0x11 then r2=0x22, and hold a third request r3=0x33.
  - count=2, wr_ready=0 and pending=0x6; r3 is not accepted.
  - Drop drain_stall: r1 commits, wr_ready=1, then r3 is accepted.
  - Final regs r1=0x11, r2=0x22, r3=0x33.
- Same-register ordering: back-to-back writes r7=0xAAAA then r7=0xBBBB -> after both commit, regs_out[7]=0xBBBB; pending[7] stays 1 until the second commit.
- Zero register: write addr 31 data 0xFFFF_FFFF_FFFF_FFFF -> accepted (count 1 then 0); regs_out[31]=0, pending[31]=0 throughout.
- Reset mid-operation: drain_stall=1, buffer r4=0x44, then assert reset -> regs_out[4]=0, count=0, and no commit occurs. With REGFILE_BYPASS_EN, regs_out[4]=0x44 before reset and 0 after.
